apb_arb_master: RTL and testbench
=================================

# apb_arb_master

Two-requester APB master that shares one APB bus among up to four register slaves. Arbitrates round-robin between requester 0 and requester 1, decodes the slave select from the request address, and sequences the SETUP/ACCESS phases while waiting on PREADY. It sits between the core-side request logic and the APB slave register blocks.

## Interface
- ADDR_W, 32: requester address width.
- DATA_W, 32: data width on requesters and APB.
- TIMEOUT_CYCLES, 16: ACCESS wait limit. Used only with APB_TIMEOUT_EN.
- PCLK  input  1  APB clock; all logic is on the rising edge.
- PRESETn  input  1  reset, asynchronous, active-low.
- reqN_valid  input  1  request from requester N (N = 0, 1).
- reqN_addr  input  ADDR_W  byte address.
- reqN_wdata  input  DATA_W  write data.
- reqN_write  input  1  1 = write, 0 = read.
- reqN_done  output  1  one-cycle completion pulse.
- reqN_rdata  output  DATA_W  read data, valid while reqN_done is high.
- reqN_err  output  1  error flag, valid while reqN_done is high.
- PADDR  output  4  equals addr[3:0] of the granted request.
- PWDATA  output  DATA_W  write data.
- PWRITE  output  1  direction.
- PSEL  output  4  one-hot slave select.
- PENABLE  output  1  ACCESS-phase indicator.
- PRDATA  input  DATA_W  read data from the selected slave.
- PREADY  input  1  transfer complete from the selected slave.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If either valid is high, choose the winner, latch its addr/wdata/write and the grant index.
  - If the decode is legal, go to SETUP. If it is illegal, go to DONE with err = 1.
- Arbitration is round-robin on last_grant. When both requesters are valid, grant the one not granted last. A single valid requester always wins. last_grant resets to 1, so requester 0 wins the first contention.
- Decode:
  - addr[13:12] selects PSEL bit 0..3.
  - addr[ADDR_W-1:14] != 0 is a decode error: no APB transfer, rdata = 0.
- SETUP: PSEL[sel] = 1, PENABLE = 0. Always advances to ACCESS.
- ACCESS: PSEL[sel] = 1, PENABLE = 1. When PREADY is sampled high, capture PRDATA (reads only; writes return 0) and go to DONE.
- DONE:
  - PSEL = 0, PENABLE = 0.
  - reqN_done = 1 for the granted requester only, with its rdata and err.
  - Next state is IDLE.
- Requester contract:
  - Hold valid and all fields stable until done.
  - Deassert valid on the clock edge at which done is sampled high.
  - A request with valid dropped before done is not allowed. The transfer completes regardless.
- Outputs never assert PSEL for more than one slave at a time.

## Timing
- Reset values: PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, reqN_done = 0, reqN_rdata = 0, reqN_err = 0. State = IDLE, last_grant = 1.
- All outputs are registered.
- Latency for a zero-wait slave (PREADY registered one cycle after PSEL && PENABLE):
  - valid seen in IDLE at cycle 0.
  - SETUP at cycle 1, ACCESS at cycles 2–3.
  - PREADY sampled at cycle 3; done at cycle 4.
  - Total: 5 cycles request-to-done.
- Decode error: done occurs 1 cycle after IDLE sampling.
- Minimum spacing between grants is one IDLE cycle after DONE. Back-to-back requests from both requesters alternate.
- Reset asserted mid-transfer: PSEL and PENABLE drop immediately (asynchronously), no done is issued, and the latched request is discarded.
- PREADY outside ACCESS is ignored.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter runs in ACCESS.
  - If PREADY has not been sampled after TIMEOUT_CYCLES ACCESS cycles, drop PSEL/PENABLE and go to DONE with err = 1, rdata = 0.
  - The counter clears on entry to SETUP.
- APB_TIMEOUT_EN undefined: ACCESS waits indefinitely, and the counter logic is absent.

## Structure
- Package apb_ctrl_pkg contains:
  - enum state_t {IDLE, SETUP, ACCESS, DONE}.
  - NUM_SLV = 4.
  - SLV_SEL_LSB = 12, SLV_SEL_MSB = 13, DEC_ERR_LSB = 14.
  - PADDR_W = 4.
- Sub-module apb_rr_arbiter:
  - Combinational grant from the two valids and last_grant.
  - Registered last_grant, updated on entry to SETUP or DONE.

## Test plan
- Write then read, single slave: req0 writes 0xDEADBEEF to 0x0000_1004, then reads 0x0000_1004.
  - PSEL = 4'b0010 and PADDR = 4'h4 for both transfers.
  - Read rdata = 0xDEADBEEF, err = 0.
  - Each transfer completes in 5 cycles.
- Contention: req0 and req1 valid in the same cycle, then both reissue.
  - Grants go req0, req1, req0, req1.
  - Only the granted requester's done pulses.
- Slave decode sweep: addresses 0x0000, 0x1000, 0x2000, 0x3000 give PSEL 0001, 0010, 0100, 1000.
- Decode error: address 0x0000_4000 gives no PSEL assertion and done with err = 1, rdata = 0.
- Reset mid-ACCESS: PRESETn driven low in ACCESS.
  - PSEL and PENABLE go to 0 the same cycle; no done.
  - After release, a new request completes normally.
- Timeout, APB_TIMEOUT_EN only: PREADY held low.
  - Done with err = 1 after 16 ACCESS cycles.
  - PSEL = 0 in the DONE cycle.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared types and address-map constants for the two-requester APB master.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam int unsigned NUM_SLV     = 4;
    localparam int unsigned SLV_SEL_LSB = 12;
    localparam int unsigned SLV_SEL_MSB = 13;
    localparam int unsigned DEC_ERR_LSB = 14;
    localparam int unsigned PADDR_W     = 4;

    function automatic logic [NUM_SLV-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_SLV-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/apb_arb_master_if.sv
// APB bus bundle between the arbitrating master and its register slaves.
interface apb_arb_master_if #(
    parameter int unsigned DATA_W = 32
);
    import apb_ctrl_pkg::*;

    logic [PADDR_W-1:0] PADDR;
    logic [DATA_W-1:0]  PWDATA;
    logic               PWRITE;
    logic [NUM_SLV-1:0] PSEL;
    logic               PENABLE;
    logic [DATA_W-1:0]  PRDATA;
    logic               PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module apb_rr_arbiter (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic update_i,
    output logic gnt_o
);

    logic last_q;

    // On contention the requester not served last wins; a lone requester always wins.
    always_comb begin
        if (valid0_i && valid1_i) begin
            gnt_o = ~last_q;
        end else begin
            gnt_o = valid1_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (update_i) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master with round-robin arbitration and slave decode; all outputs registered.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES with an error.
module apb_arb_master
    import apb_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,

    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    input  logic              req0_write_i,
    output logic              req0_done_o,
    output logic [DATA_W-1:0] req0_rdata_o,
    output logic              req0_err_o,

    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    input  logic              req1_write_i,
    output logic              req1_done_o,
    output logic [DATA_W-1:0] req1_rdata_o,
    output logic              req1_err_o,

    apb_arb_master_if.master  apb
);

    state_t             state_q, state_d;
    logic               gnt, any_valid, arb_update;
    logic               gnt_q, gnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [PADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic               penable_q, penable_d;
    logic [1:0]         done_q, done_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic               done_n, err_n, done_idx;
    logic [DATA_W-1:0]  rdata_n;

    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic               win_write, win_dec_err;
    logic [1:0]         win_sel;
    logic               tmo_hit;
    logic               unused_addr_bits;

    assign any_valid  = req0_valid_i | req1_valid_i;
    assign arb_update = (state_q == IDLE) && any_valid;

    apb_rr_arbiter u_arb (
        .clk_i    (PCLK),
        .rst_ni   (PRESETn),
        .valid0_i (req0_valid_i),
        .valid1_i (req1_valid_i),
        .update_i (arb_update),
        .gnt_o    (gnt)
    );

    assign win_addr         = gnt ? req1_addr_i  : req0_addr_i;
    assign win_wdata        = gnt ? req1_wdata_i : req0_wdata_i;
    assign win_write        = gnt ? req1_write_i : req0_write_i;
    assign win_sel          = win_addr[SLV_SEL_MSB:SLV_SEL_LSB];
    assign win_dec_err      = |win_addr[ADDR_W-1:DEC_ERR_LSB];
    assign unused_addr_bits = ^win_addr[SLV_SEL_LSB-1:PADDR_W];

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_d == SETUP) begin
            tmo_cnt_d = '0;
        end else if (state_q == ACCESS) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_valid) state_d = win_dec_err ? DONE : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb.PREADY || tmo_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed for the cycle after the edge, then registered.
    always_comb begin
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = '0;
        penable_d = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        rdata_n   = '0;
        done_idx  = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    gnt_d = gnt;
                    if (win_dec_err) begin
                        done_n   = 1'b1;
                        err_n    = 1'b1;
                        done_idx = gnt;
                    end else begin
                        sel_d    = win_sel;
                        paddr_d  = win_addr[PADDR_W-1:0];
                        pwdata_d = win_wdata;
                        pwrite_d = win_write;
                        psel_d   = sel_onehot(win_sel);
                    end
                end
            end
            SETUP: begin
                psel_d    = sel_onehot(sel_q);
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    done_n  = 1'b1;
                    rdata_n = pwrite_q ? '0 : apb.PRDATA;
                end else if (tmo_hit) begin
                    done_n = 1'b1;
                    err_n  = 1'b1;
                end else begin
                    psel_d    = sel_onehot(sel_q);
                    penable_d = 1'b1;
                end
            end
            DONE: begin
                done_n = 1'b0;
            end
            default: begin
                done_n = 1'b0;
            end
        endcase
        done_d   = {done_n & done_idx, done_n & ~done_idx};
        rdata0_d = done_d[0] ? rdata_n : '0;
        rdata1_d = done_d[1] ? rdata_n : '0;
        err0_d   = done_d[0] & err_n;
        err1_d   = done_d[1] & err_n;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            sel_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            done_q    <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            done_q    <= done_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign apb.PADDR    = paddr_q;
    assign apb.PWDATA   = pwdata_q;
    assign apb.PWRITE   = pwrite_q;
    assign apb.PSEL     = psel_q;
    assign apb.PENABLE  = penable_q;
    assign req0_done_o  = done_q[0];
    assign req1_done_o  = done_q[1];
    assign req0_rdata_o = rdata0_q;
    assign req1_rdata_o = rdata1_q;
    assign req0_err_o   = err0_q;
    assign req1_err_o   = err1_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Randomized bench for apb_arb_master checked against a transaction-level reference model.
// Defining APB_TIMEOUT_EN also exercises the ACCESS timeout.
module tb_apb_arb_master;

    localparam int unsigned AW          = 32;
    localparam int unsigned DW          = 32;
    localparam int unsigned TMO         = 16;
    localparam int unsigned EDGE_BUDGET = 200;

    typedef struct {
        int unsigned   req;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            write;
    } txn_t;

    logic          PCLK    = 1'b0;
    logic          PRESETn = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr  = '0,   req1_addr  = '0;
    logic [DW-1:0] req0_wdata = '0,   req1_wdata = '0;
    logic          req0_write = 1'b0, req1_write = 1'b0;
    logic          req0_done, req1_done, req0_err, req1_err;
    logic [DW-1:0] req0_rdata, req1_rdata;

    always #5 PCLK = ~PCLK;

    apb_arb_master_if #(.DATA_W(DW)) apb ();

    apb_arb_master #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .req0_valid_i (req0_valid),
        .req0_addr_i  (req0_addr),
        .req0_wdata_i (req0_wdata),
        .req0_write_i (req0_write),
        .req0_done_o  (req0_done),
        .req0_rdata_o (req0_rdata),
        .req0_err_o   (req0_err),
        .req1_valid_i (req1_valid),
        .req1_addr_i  (req1_addr),
        .req1_wdata_i (req1_wdata),
        .req1_write_i (req1_write),
        .req1_done_o  (req1_done),
        .req1_rdata_o (req1_rdata),
        .req1_err_o   (req1_err),
        .apb          (apb)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int unsigned i);
        return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    // ---- APB slave environment: four 16-word register files, programmable wait states ----
    logic [DW-1:0] slave_mem [64];
    logic          mem_init = 1'b0;
    int unsigned   wait_cfg = 0;
    bit            stall    = 1'b0;
    int unsigned   wcnt;
    logic [1:0]    slv_idx;
    logic          slv_hit;

    always_comb begin
        slv_hit = 1'b1;
        slv_idx = 2'd0;
        case (apb.PSEL)
            4'b0001: slv_idx = 2'd0;
            4'b0010: slv_idx = 2'd1;
            4'b0100: slv_idx = 2'd2;
            4'b1000: slv_idx = 2'd3;
            default: slv_hit = 1'b0;
        endcase
        apb.PRDATA = slv_hit ? slave_mem[{slv_idx, apb.PADDR}] : '0;
    end

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            apb.PREADY <= 1'b0;
            wcnt       <= 0;
        end else if (slv_hit && apb.PENABLE && !apb.PREADY) begin
            if (!stall) begin
                if (wcnt == 0) apb.PREADY <= 1'b1;
                else wcnt <= wcnt - 1;
            end
        end else begin
            apb.PREADY <= 1'b0;
            wcnt       <= wait_cfg;
        end
    end

    always @(posedge PCLK) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) slave_mem[i] <= init_word(i);
        end else if (slv_hit && apb.PENABLE && apb.PREADY && apb.PWRITE) begin
            slave_mem[{slv_idx, apb.PADDR}] <= apb.PWDATA;
        end
    end

    // ---- Reference model: address map, register contents and fairness pointer ----
    logic [DW-1:0] ref_mem [64];
    int unsigned   last_m = 1;

    function automatic bit m_dec_err(input logic [AW-1:0] a);
        return a[AW-1:14] != '0;
    endfunction

    function automatic int unsigned m_key(input logic [AW-1:0] a);
        return 32'(a[13:12]) * 16 + 32'(a[3:0]);
    endfunction

    function automatic txn_t mk_txn(input int unsigned r, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d, input bit w);
        txn_t t;
        t.req   = r;
        t.addr  = a;
        t.wdata = d;
        t.write = w;
        return t;
    endfunction

    function automatic txn_t rand_txn(input int unsigned r, input bit allow_err);
        txn_t t;
        t.req   = r;
        t.write = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.addr  = $urandom & 32'h0000_3FFF;
        if (allow_err && $urandom_range(0, 7) == 0) t.addr[14 + $urandom_range(0, 17)] = 1'b1;
        return t;
    endfunction

    // Issue one round (one or both requesters valid together) and check every resulting transfer.
    task automatic run_round(input bit [1:0] mask, input txn_t t0, input txn_t t1,
                             input int unsigned w, input bit st);
        txn_t        order[$];
        txn_t        t;
        int unsigned edge_n, start, cur, lat;
        bit [1:0]    drop;
        bit          prev_psel, e_err;
        logic [3:0]  exp_psel;
        logic [DW-1:0] e_rdata, a_rdata;
        logic        a_err;

        wait_cfg = w;
        stall    = st;
        if (mask == 2'b11) begin
            if (last_m == 1) begin order.push_back(t0); order.push_back(t1); end
            else begin order.push_back(t1); order.push_back(t0); end
        end else if (mask[0]) order.push_back(t0);
        else order.push_back(t1);

        @(posedge PCLK);
        #1;
        if (mask[0]) begin
            req0_addr = t0.addr; req0_wdata = t0.wdata; req0_write = t0.write; req0_valid = 1'b1;
        end
        if (mask[1]) begin
            req1_addr = t1.addr; req1_wdata = t1.wdata; req1_write = t1.write; req1_valid = 1'b1;
        end

        edge_n = 0; start = 0; cur = 0; drop = '0; prev_psel = 1'b0;
        while (cur < order.size() && edge_n < EDGE_BUDGET) begin
            @(posedge PCLK);
            edge_n++;
            #1;
            if (drop[0]) req0_valid = 1'b0;
            if (drop[1]) req1_valid = 1'b0;
            drop = '0;
            @(negedge PCLK);
            t = order[cur];
            if (apb.PSEL != '0) begin
                exp_psel = m_dec_err(t.addr) ? 4'd0 : (4'b0001 << t.addr[13:12]);
                check_val("psel", 64'(apb.PSEL), 64'(exp_psel));
                check_val("paddr", 64'(apb.PADDR), 64'(t.addr[3:0]));
                check_val("pwrite", 64'(apb.PWRITE), 64'(t.write));
                if (t.write) check_val("pwdata", 64'(apb.PWDATA), 64'(t.wdata));
                if (!prev_psel) check_val("setup_penable", 64'(apb.PENABLE), 64'd0);
                else check_val("access_penable", 64'(apb.PENABLE), 64'd1);
            end
            prev_psel = |apb.PSEL;
            if (req0_done || req1_done) begin
                e_err   = m_dec_err(t.addr) || st;
                lat     = m_dec_err(t.addr) ? 1 : (st ? 2 + TMO : 4 + w);
                e_rdata = (e_err || t.write) ? '0 : ref_mem[m_key(t.addr)];
                a_rdata = (t.req == 1) ? req1_rdata : req0_rdata;
                a_err   = (t.req == 1) ? req1_err : req0_err;
                check_val("done_who", 64'({req1_done, req0_done}), 64'(2'b01 << t.req));
                check_val("latency", 64'(edge_n), 64'(start + lat));
                check_val("rdata", 64'(a_rdata), 64'(e_rdata));
                check_val("err", 64'(a_err), 64'(e_err));
                check_val("done_psel", 64'(apb.PSEL), 64'd0);
                if (t.write && !e_err) ref_mem[m_key(t.addr)] = t.wdata;
                last_m = t.req;
                drop[t.req] = 1'b1;
                start = edge_n + 1;
                cur++;
            end
        end
        if (cur < order.size()) check_val("round_timeout", 64'(cur), 64'(order.size()));
        @(posedge PCLK);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        stall      = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge PCLK);
            check_val("idle_done", 64'({req1_done, req0_done}), 64'd0);
        end
    endtask

    txn_t        nil;
    bit [1:0]    mask;

    initial begin
        nil = mk_txn(0, '0, '0, 1'b0);
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        mem_init = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        check_val("rst_psel", 64'(apb.PSEL), 64'd0);
        check_val("rst_penable", 64'(apb.PENABLE), 64'd0);
        check_val("rst_pwrite", 64'(apb.PWRITE), 64'd0);
        check_val("rst_paddr", 64'(apb.PADDR), 64'd0);
        check_val("rst_pwdata", 64'(apb.PWDATA), 64'd0);
        check_val("rst_done", 64'({req1_done, req0_done}), 64'd0);
        check_val("rst_rdata0", 64'(req0_rdata), 64'd0);
        check_val("rst_rdata1", 64'(req1_rdata), 64'd0);
        check_val("rst_err", 64'({req1_err, req0_err}), 64'd0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        mem_init = 1'b0;
        PRESETn  = 1'b1;

        // Contention from reset: req0, req1, then again req0, req1.
        run_round(2'b11, rand_txn(0, 1'b0), rand_txn(1, 1'b0), 0, 1'b0);
        idle(1);
        run_round(2'b11, rand_txn(0, 1'b0), rand_txn(1, 1'b0), 0, 1'b0);
        idle(1);

        // Write then read back through slave 1.
        run_round(2'b01, mk_txn(0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1), nil, 0, 1'b0);
        run_round(2'b01, mk_txn(0, 32'h0000_1004, 32'h0, 1'b0), nil, 0, 1'b0);
        check_val("readback_model", 64'(ref_mem[m_key(32'h0000_1004)]), 64'h0000_0000_DEAD_BEEF);

        for (int s = 0; s < 4; s++) begin
            run_round(2'b10, nil, mk_txn(1, 32'(s) << 12, 32'h0, 1'b0), 0, 1'b0);
        end
        run_round(2'b01, mk_txn(0, 32'h0000_4000, 32'h0, 1'b0), nil, 0, 1'b0);
        idle(2);

        repeat (150) begin
            mask = 2'($urandom_range(1, 3));
            run_round(mask, rand_txn(0, 1'b1), rand_txn(1, 1'b1), $urandom_range(0, 3), 1'b0);
            idle($urandom_range(0, 2));
        end

        // Reset in the middle of an ACCESS phase; the write must never land.
        wait_cfg = 3;
        @(posedge PCLK);
        #1;
        req0_addr = 32'h0000_2008; req0_wdata = 32'hCAFE_F00D; req0_write = 1'b1;
        req0_valid = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check_val("pre_rst_penable", 64'(apb.PENABLE), 64'd1);
        #2 PRESETn = 1'b0;
        #1;
        check_val("mid_rst_psel", 64'(apb.PSEL), 64'd0);
        check_val("mid_rst_penable", 64'(apb.PENABLE), 64'd0);
        req0_valid = 1'b0;
        last_m     = 1;
        idle(3);
        PRESETn = 1'b1;
        run_round(2'b01, mk_txn(0, 32'h0000_2008, 32'h0, 1'b0), nil, 0, 1'b0);
        run_round(2'b11, rand_txn(0, 1'b0), rand_txn(1, 1'b0), 1, 1'b0);

`ifdef APB_TIMEOUT_EN
        run_round(2'b01, mk_txn(0, 32'h0000_3004, 32'h0, 1'b0), nil, 0, 1'b1);
        run_round(2'b10, nil, mk_txn(1, 32'h0000_3004, 32'h0, 1'b0), 0, 1'b0);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
